// File: rtl/imem_responder.sv
// Instruction-memory responder for the RV32IC fetch stage: fixed-latency word reads, compressed
// detection and word-straddle stitching. Define IMEM_LINEBUF_EN to add a one-entry line buffer.
module imem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_instr,
  output logic [31:0] resp_pc,
  output logic        resp_compressed,
  output logic        resp_fault,
  input  logic        flush,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StReadLo, StReadHi, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] mem [DEPTH];
  logic [31:0] addr_q;
  logic [2:0]  cnt_q;
  logic [31:0] lo_word_q;
  logic [31:0] resp_instr_q, resp_pc_q;
  logic        resp_compressed_q, resp_fault_q;

  logic        accept;
  logic [31:0] word_idx, rd_idx, wr_idx;
  logic        rd_oob, hi_oob, wr_in_range;
  logic [31:0] mem_word, rd_word;
  logic        lb_hit, in_read, done;
  logic [15:0] half;
  logic        lo_comp, lo_fault, need_hi;
  logic        unused_bits;

  assign unused_bits = ^{req_addr[0], wr_addr[1:0]};

  assign accept      = req_valid && req_ready;
  assign word_idx    = {2'b00, addr_q[31:2]};
  // 32-bit index arithmetic so the straddle word of the top address cannot wrap into range
  assign rd_idx      = word_idx + ((state_q == StReadHi) ? 32'd1 : 32'd0);
  assign rd_oob      = rd_idx >= DEPTH;
  assign hi_oob      = (word_idx + 32'd1) >= DEPTH;
  assign wr_idx      = {2'b00, wr_addr[31:2]};
  assign wr_in_range = wr_idx < DEPTH;
  assign mem_word    = rd_oob ? 32'h0 : mem[rd_idx[AW-1:0]];

  assign in_read  = (state_q == StReadLo) || (state_q == StReadHi);
  assign done     = in_read && ((cnt_q == 3'd1) || lb_hit);
  assign half     = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
  assign lo_comp  = half[1:0] != 2'b11;
  assign lo_fault = rd_oob || (addr_q[1] && !lo_comp && hi_oob);
  assign need_hi  = !lo_fault && !lo_comp && addr_q[1];

`ifdef IMEM_LINEBUF_EN
  logic        lb_valid_q;
  logic [31:0] lb_idx_q, lb_data_q;
  logic        lb_fill;

  assign lb_hit  = lb_valid_q && (lb_idx_q == rd_idx);
  assign rd_word = lb_hit ? lb_data_q : mem_word;
  assign lb_fill = done && !rd_oob && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lb_valid_q <= 1'b0;
      lb_idx_q   <= 32'h0;
      lb_data_q  <= 32'h0;
    end else if (flush) begin
      lb_valid_q <= 1'b0;
    end else if (lb_fill) begin
      // A write to the word being captured makes the captured copy stale
      lb_valid_q <= !(wr_en && wr_in_range && (wr_idx == rd_idx));
      lb_idx_q   <= rd_idx;
      lb_data_q  <= rd_word;
    end else if (wr_en && wr_in_range && (wr_idx == lb_idx_q)) begin
      lb_valid_q <= 1'b0;
    end
  end
`else
  assign lb_hit  = 1'b0;
  assign rd_word = mem_word;
`endif

  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      mem[wr_idx[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StReadLo;
      StReadLo: if (done) state_d = need_hi ? StReadHi : StResp;
      StReadHi: if (done) state_d = StResp;
      StResp:   if (resp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_comb begin
    req_ready  = (state_q == StIdle) && !flush && !reset;
    resp_valid = state_q == StResp;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q            <= 32'h0;
      cnt_q             <= 3'd0;
      lo_word_q         <= 32'h0;
      resp_instr_q      <= 32'h0;
      resp_pc_q         <= 32'h0;
      resp_compressed_q <= 1'b0;
      resp_fault_q      <= 1'b0;
    end else if (flush) begin
      cnt_q <= 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            addr_q <= {req_addr[31:1], 1'b0};
            cnt_q  <= 3'(LATENCY);
          end
        end
        StReadLo: begin
          if (done) begin
            lo_word_q         <= rd_word;
            resp_pc_q         <= addr_q;
            resp_fault_q      <= lo_fault;
            resp_compressed_q <= !lo_fault && lo_comp;
            resp_instr_q      <= lo_fault ? 32'h0 : (lo_comp ? {16'h0, half} : rd_word);
            cnt_q             <= need_hi ? 3'(LATENCY) : 3'd0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StReadHi: begin
          if (done) begin
            resp_instr_q      <= {rd_word[15:0], lo_word_q[31:16]};
            resp_compressed_q <= 1'b0;
            resp_fault_q      <= 1'b0;
            cnt_q             <= 3'd0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign resp_instr      = resp_instr_q;
  assign resp_pc         = resp_pc_q;
  assign resp_compressed = resp_compressed_q;
  assign resp_fault      = resp_fault_q;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder (DEPTH=16, LATENCY=2); line-buffer timing follows
// IMEM_LINEBUF_EN when it is defined for the build.
module tb_imem_responder;

  localparam int DEPTH   = 16;
  localparam int LATENCY = 2;
`ifdef IMEM_LINEBUF_EN
  localparam bit LineBuf = 1'b1;
`else
  localparam bit LineBuf = 1'b0;
`endif

  logic        clk, reset;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_instr, resp_pc;
  logic        resp_compressed, resp_fault;
  logic        flush, wr_en;
  logic [31:0] wr_addr, wr_data;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        comp;
    logic        fault;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          passed, total;
  logic        m_lb_v;
  logic [31:0] m_lb_i;

  imem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
    .resp_pc(resp_pc), .resp_compressed(resp_compressed), .resp_fault(resp_fault),
    .flush(flush), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Cost of one word read, tracking the line buffer the way the design should
  function automatic int word_cost(input logic [31:0] idx);
    int c = LATENCY;
    if (LineBuf && m_lb_v && m_lb_i == idx) c = 1;
    if (idx < DEPTH) begin
      m_lb_v = 1'b1;
      m_lb_i = idx;
    end
    return c;
  endfunction

  function automatic int req_cost(input logic [31:0] addr, input logic comp, input logic fault);
    logic [31:0] idx;
    int c;
    idx = {2'b00, addr[31:2]};
    c = word_cost(idx);
    if (addr[1] && !comp && !fault) c += word_cost(idx + 32'd1);
    return c;
  endfunction

  task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    if ((addr >> 2) < DEPTH && m_lb_v && m_lb_i == (addr >> 2)) m_lb_v = 1'b0;
  endtask

  // Issue one request; lat = edges from acceptance until resp_valid is seen, -1 on timeout
  task automatic do_req(input logic [31:0] addr, output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (req_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", req_ready);
    else passed++;
    total++;
    if ({resp_valid, resp_instr, resp_pc, resp_compressed, resp_fault} !== 67'h0)
      $display("FAIL reset_outputs: got v=%b i=%h pc=%h c=%b f=%b want all 0",
               resp_valid, resp_instr, resp_pc, resp_compressed, resp_fault);
    else passed++;
    reset = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b want 1", req_ready);
    else passed++;
  endtask

  task automatic test_aligned();
    logic [31:0] addrs [6];
    logic [31:0] instrs [6];
    logic [0:5]  cmp;
    exp_t e;
    int lat;
    addrs  = '{32'h0, 32'h1, 32'h2, 32'h4, 32'h6, 32'h8};
    instrs = '{32'h0050_0093, 32'h0050_0093, 32'h0000_0050,
               32'h0000_0001, 32'h0000_4505, 32'h0000_4501};
    cmp = 6'b001111;
    for (int i = 0; i < 6; i++) begin
      e.instr = instrs[i]; e.pc = {addrs[i][31:1], 1'b0}; e.comp = cmp[i]; e.fault = 1'b0;
      e.lat = req_cost(addrs[i], cmp[i], 1'b0);
      sb.push_back(e);
      do_req(addrs[i], lat);
      e = sb.pop_front();
      total++;
      if ({resp_instr, resp_pc, resp_compressed, resp_fault} !== {e.instr, e.pc, e.comp, e.fault})
        $display("FAIL aligned[%0d]: got i=%h pc=%h c=%b f=%b want i=%h pc=%h c=%b f=%b", i,
                 resp_instr, resp_pc, resp_compressed, resp_fault, e.instr, e.pc, e.comp, e.fault);
      else passed++;
      total++;
      if (lat !== e.lat) $display("FAIL aligned_lat[%0d]: got %0d want %0d", i, lat, e.lat);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_straddle();
    logic [31:0] addrs [2];
    logic [31:0] instrs [2];
    logic [0:1]  cmp;
    exp_t e;
    int lat;
    addrs  = '{32'hA, 32'hE};
    instrs = '{32'h0050_0093, 32'h0000_1234};
    cmp = 2'b01;
    for (int i = 0; i < 2; i++) begin
      e.instr = instrs[i]; e.pc = addrs[i]; e.comp = cmp[i]; e.fault = 1'b0;
      e.lat = req_cost(addrs[i], cmp[i], 1'b0);
      sb.push_back(e);
      do_req(addrs[i], lat);
      e = sb.pop_front();
      total++;
      if ({resp_instr, resp_pc, resp_compressed, resp_fault} !== {e.instr, e.pc, e.comp, e.fault})
        $display("FAIL straddle[%0d]: got i=%h pc=%h c=%b f=%b want i=%h pc=%h c=%b f=%b", i,
                 resp_instr, resp_pc, resp_compressed, resp_fault, e.instr, e.pc, e.comp, e.fault);
      else passed++;
      total++;
      if (lat !== e.lat) $display("FAIL straddle_lat[%0d]: got %0d want %0d", i, lat, e.lat);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_fault();
    logic [31:0] addrs [4];
    logic [31:0] instrs [4];
    logic [0:3]  cmp, flt;
    exp_t e;
    int lat;
    addrs  = '{32'h40, 32'h3C, 32'h3E, 32'hFFFF_FFFC};
    instrs = '{32'h0, 32'h0000_0002, 32'h0, 32'h0};
    cmp = 4'b0100;
    flt = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      e.instr = instrs[i]; e.pc = addrs[i]; e.comp = cmp[i]; e.fault = flt[i];
      e.lat = req_cost(addrs[i], cmp[i], flt[i]);
      sb.push_back(e);
      do_req(addrs[i], lat);
      e = sb.pop_front();
      total++;
      if ({resp_instr, resp_pc, resp_compressed, resp_fault} !== {e.instr, e.pc, e.comp, e.fault})
        $display("FAIL fault[%0d]: got i=%h pc=%h c=%b f=%b want i=%h pc=%h c=%b f=%b", i,
                 resp_instr, resp_pc, resp_compressed, resp_fault, e.instr, e.pc, e.comp, e.fault);
      else passed++;
      total++;
      if (lat !== e.lat) $display("FAIL fault_lat[%0d]: got %0d want %0d", i, lat, e.lat);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_flush();
    logic seen;
    exp_t e;
    int lat;
    int lo;
    seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'hA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lo = word_cost(32'd2);
    repeat (lo) begin
      @(posedge clk); #1;
      seen |= resp_valid;
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    m_lb_v = 1'b0;
    seen |= resp_valid;
    @(negedge clk);
    total++;
    if (req_ready !== 1'b1) $display("FAIL flush_ready: got %b want 1", req_ready);
    else passed++;
    repeat (2 * LATENCY + 2) begin
      @(posedge clk); #1;
      seen |= resp_valid;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL flush_drop: resp_valid seen=%b want 0", seen);
    else passed++;
    e.instr = 32'h0050_0093; e.pc = 32'h0; e.comp = 1'b0; e.fault = 1'b0;
    e.lat = req_cost(32'h0, 1'b0, 1'b0);
    sb.push_back(e);
    do_req(32'h0, lat);
    e = sb.pop_front();
    total++;
    if ({resp_instr, resp_pc, resp_compressed, resp_fault} !== {e.instr, e.pc, e.comp, e.fault}
        || lat !== e.lat)
      $display("FAIL after_flush: got i=%h pc=%h c=%b f=%b lat=%0d want i=%h pc=%h c=%b f=%b lat=%0d",
               resp_instr, resp_pc, resp_compressed, resp_fault, lat,
               e.instr, e.pc, e.comp, e.fault, e.lat);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_flush_with_req();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0; flush = 1'b1;
    #1;
    total++;
    if (req_ready !== 1'b0) $display("FAIL flush_req_ready: got %b want 0", req_ready);
    else passed++;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    m_lb_v = 1'b0;
    repeat (LATENCY + 3) begin
      @(posedge clk); #1;
      seen |= resp_valid;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL flush_req_not_accepted: resp_valid seen=%b want 0", seen);
    else passed++;
    total++;
    if (req_ready !== 1'b1) $display("FAIL flush_req_idle: got %b want 1", req_ready);
    else passed++;
  endtask

  task automatic test_backpressure();
    exp_t e;
    int lat;
    resp_ready = 1'b0;
    e.instr = 32'h0050_0093; e.pc = 32'h0; e.comp = 1'b0; e.fault = 1'b0;
    e.lat = req_cost(32'h0, 1'b0, 1'b0);
    sb.push_back(e);
    do_req(32'h0, lat);
    e = sb.pop_front();
    total++;
    if (lat !== e.lat) $display("FAIL bp_lat: got %0d want %0d", lat, e.lat);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({resp_valid, resp_instr, resp_pc, resp_compressed, resp_fault}
          !== {1'b1, e.instr, e.pc, e.comp, e.fault})
        $display("FAIL bp_hold[%0d]: got v=%b i=%h want v=1 i=%h", i, resp_valid, resp_instr,
                 e.instr);
      else passed++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({resp_valid, req_ready} !== 2'b01)
      $display("FAIL bp_release: got v=%b ready=%b want v=0 ready=1", resp_valid, req_ready);
    else passed++;
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'hA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    total++;
    if ({resp_valid, req_ready, resp_instr, resp_pc} !== 66'h0)
      $display("FAIL reset_mid: got v=%b ready=%b i=%h pc=%h want all 0", resp_valid, req_ready,
               resp_instr, resp_pc);
    else passed++;
    m_lb_v = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    total++;
    if (req_ready !== 1'b1) $display("FAIL reset_mid_ready: got %b want 1", req_ready);
    else passed++;
    repeat (2 * LATENCY + 2) begin
      @(posedge clk); #1;
      seen |= resp_valid;
    end
    total++;
    if (seen !== 1'b0) $display("FAIL reset_mid_drop: resp_valid seen=%b want 0", seen);
    else passed++;
  endtask

  task automatic test_write_invalidate();
    logic [31:0] instrs [3];
    exp_t e;
    int lat;
    instrs = '{32'h0050_0093, 32'h0050_0093, 32'h0010_0113};
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        write_word(32'h0, 32'h0010_0113);
        write_word(32'h40, 32'hDEAD_BEEF);
      end
      e.instr = instrs[i]; e.pc = 32'h0; e.comp = 1'b0; e.fault = 1'b0;
      e.lat = req_cost(32'h0, 1'b0, 1'b0);
      sb.push_back(e);
      do_req(32'h0, lat);
      e = sb.pop_front();
      total++;
      if ({resp_instr, resp_pc, resp_compressed, resp_fault} !== {e.instr, e.pc, e.comp, e.fault})
        $display("FAIL wr_inval[%0d]: got i=%h pc=%h c=%b f=%b want i=%h pc=%h c=%b f=%b", i,
                 resp_instr, resp_pc, resp_compressed, resp_fault, e.instr, e.pc, e.comp, e.fault);
      else passed++;
      total++;
      if (lat !== e.lat) $display("FAIL wr_inval_lat[%0d]: got %0d want %0d", i, lat, e.lat);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    passed = 0; total = 0;
    m_lb_v = 1'b0; m_lb_i = 32'h0;
    reset = 1'b1; req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b1;
    flush = 1'b0; wr_en = 1'b0; wr_addr = 32'h0; wr_data = 32'h0;
    test_reset();
    write_word(32'h00, 32'h0050_0093);
    write_word(32'h04, 32'h4505_0001);
    write_word(32'h08, 32'h0093_4501);
    write_word(32'h0C, 32'h1234_0050);
    write_word(32'h3C, 32'hFFFF_0002);
    test_aligned();
    test_straddle();
    test_fault();
    test_flush();
    test_flush_with_req();
    test_backpressure();
    test_reset_mid();
    test_write_invalidate();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
